// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Used by serial_subtractor (optional SERIAL_SUB_OVF_EN adds ovf).
package serial_subtractor_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Never returns 0 so a counter is at least one bit wide
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level one-bit full subtractor: d = a - b - Bin.
// Bout is the borrow into the next bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic Bin,
    output logic d,
    output logic Bout
);

    logic axb, na, naxb, t1, t2;

    xor g0 (axb, a, b);
    xor g1 (d, axb, Bin);
    not g2 (na, a);
    and g3 (t1, na, b);
    not g4 (naxb, axb);
    and g5 (t2, naxb, Bin);
    or  g6 (Bout, t1, t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with start/busy/done.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = clog2(WIDTH);

    state_t state, state_nxt;

    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             d, bnext;
    logic             load, step, last;

    full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .Bin  (borrow),
        .d    (d),
        .Bout (bnext)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // diff is the result shift register itself, so it holds between runs
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (load) begin
            sa     <= a;
            sb     <= b;
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (step) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            cnt    <= cnt + CW'(1);
            borrow <= bnext;
            diff   <= {d, diff[WIDTH-1:1]};
            if (last) bout <= bnext;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // On the last step sa[0]/sb[0] are the operand MSBs and d is diff MSB
    always_ff @(posedge clk) begin
        if (rst)              ovf <= 1'b0;
        else if (step && last) ovf <= (sa[0] ^ sb[0]) & (d ^ sa[0]);
    end
`endif

endmodule
